membus_uart: RTL and testbench

- Memory-mapped UART peripheral on the CPU membus. It sits beside membus_axi_master, downstream of core_port, and is selected by the membus address decoder.
- Provides a FIFO-buffered 8N1 transmitter that drives the board UART_TX pin (currently tied idle), a status register, and an optional receiver on UART_RX.
- The core writes characters and polls status; no interrupts.

---
 rtl/membus_uart_pkg.sv | 49 ++++
 rtl/membus_uart_fifo.sv | 64 ++++++
 rtl/membus_uart.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_membus_uart.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/membus_uart_pkg.sv
// membus_uart_pkg: register offsets, STATUS bit positions and FSM state types
// shared by the membus UART peripheral.
package membus_uart_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RXDATA = 2'd2;

   localparam int unsigned ST_TX_FULL    = 0;
   localparam int unsigned ST_TX_EMPTY   = 1;
   localparam int unsigned ST_TX_BUSY    = 2;
   localparam int unsigned ST_COUNT_LSB  = 8;
   localparam int unsigned ST_RX_VALID   = 16;
   localparam int unsigned ST_RX_OVERRUN = 17;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   function automatic logic [63:0] pack_status(
      input logic       full,
      input logic       empty,
      input logic       busy,
      input logic [7:0] count,
      input logic       rx_valid,
      input logic       rx_overrun
   );
      logic [63:0] s;
      s                      = '0;
      s[ST_TX_FULL]          = full;
      s[ST_TX_EMPTY]         = empty;
      s[ST_TX_BUSY]          = busy;
      s[ST_COUNT_LSB +: 8]   = count;
      s[ST_RX_VALID]         = rx_valid;
      s[ST_RX_OVERRUN]       = rx_overrun;
      return s;
   endfunction

endpackage

// File: rtl/membus_uart_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
// Full/empty derive from the registered count; a push while full is dropped
// even if a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_din,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // storage array, written on accepted pushes
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // pointers and occupancy count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/membus_uart.sv
// membus_uart: memory-mapped 8N1 UART with a FIFO-buffered transmitter and
// a polled STATUS register. The optional receiver is built only when the
// macro MEMBUS_UART_RX_EN is defined; otherwise uart_rx is ignored and the
// RX status bits / RXDATA read as zero.
module membus_uart
   import membus_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = 868,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic        mem_wen,
   input  logic [63:0] mem_wdata,
   input  logic [7:0]  mem_wmask,
   output logic        mem_rvalid,
   output logic [63:0] mem_rdata,
   input  logic        uart_rx,
   output logic        uart_tx
);

   localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   // bus side
   logic [1:0]  w_sel;
   logic        w_accept;
   logic        w_push;
   logic        w_rd_status;
   logic        w_rd_rxdata;
   logic [63:0] w_read_val;
   logic        r_rvalid;
   logic [63:0] r_rdata;

   // FIFO side
   logic [7:0]    w_fifo_dout;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic          w_pop;

   // TX FSM
   tx_state_t   r_tx_state, w_tx_state_nxt;
   logic [15:0] r_baud, w_baud_nxt;
   logic [2:0]  r_bit_idx, w_bit_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_tx, w_tx_nxt;

   // RX view presented to the register map
   logic       w_rx_valid;
   logic       w_rx_overrun;
   logic [7:0] w_rx_byte;

   logic w_unused;

   assign w_sel       = mem_addr[4:3];
   assign mem_ready   = ~(mem_valid & mem_wen & (w_sel == REG_TXDATA) & mem_wmask[0] & w_full);
   assign w_accept    = mem_valid & mem_ready;
   assign w_push      = w_accept & mem_wen & (w_sel == REG_TXDATA) & mem_wmask[0];
   assign w_rd_status = w_accept & ~mem_wen & (w_sel == REG_STATUS);
   assign w_rd_rxdata = w_accept & ~mem_wen & (w_sel == REG_RXDATA);

   assign mem_rvalid  = r_rvalid;
   assign mem_rdata   = r_rdata;
   assign uart_tx     = r_tx;

   assign w_unused = ^{mem_addr[31:5], mem_addr[2:0], mem_wdata[63:8], mem_wmask[7:1],
                       uart_rx, w_rd_status, w_rd_rxdata};

   sync_fifo #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (mem_wdata[7:0]),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // register-map read mux, sampled in the accept cycle
   always_comb begin
      w_read_val = '0;
      case (w_sel)
         REG_STATUS: w_read_val = pack_status(w_full, w_empty, (r_tx_state != TX_IDLE),
                                              8'(w_count), w_rx_valid, w_rx_overrun);
         REG_RXDATA: w_read_val = {56'd0, w_rx_byte};
         default:    w_read_val = '0;
      endcase
   end

   // one response per accepted request, one cycle later; writes return zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_accept;
         r_rdata  <= (w_accept & ~mem_wen) ? w_read_val : '0;
      end
   end

   // TX state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_baud     <= w_baud_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
      end
   end

   // TX next state; uart_tx is loaded one cycle ahead so the pin is a flop
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_baud_nxt     = r_baud;
      w_bit_nxt      = r_bit_idx;
      w_shift_nxt    = r_shift;
      w_tx_nxt       = r_tx;
      w_pop          = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_nxt = 1'b1;
            if (!w_empty) begin
               w_pop          = 1'b1;
               w_shift_nxt    = w_fifo_dout;
               w_baud_nxt     = BAUD_LAST;
               w_tx_nxt       = 1'b0;
               w_tx_state_nxt = TX_START;
            end
         end
         TX_START: begin
            if (r_baud == '0) begin
               w_baud_nxt     = BAUD_LAST;
               w_bit_nxt      = '0;
               w_tx_nxt       = r_shift[0];
               w_tx_state_nxt = TX_DATA;
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         TX_DATA: begin
            if (r_baud == '0) begin
               w_baud_nxt = BAUD_LAST;
               if (r_bit_idx == 3'd7) begin
                  w_tx_nxt       = 1'b1;
                  w_tx_state_nxt = TX_STOP;
               end else begin
                  w_bit_nxt   = r_bit_idx + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         TX_STOP: begin
            w_tx_nxt = 1'b1;
            if (r_baud == '0) begin
               w_tx_state_nxt = TX_IDLE;
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         default: begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_nxt       = 1'b1;
         end
      endcase
   end

`ifdef MEMBUS_UART_RX_EN
   localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

   rx_state_t   r_rx_state, w_rx_state_nxt;
   logic        r_rx_s1, r_rx_s2, r_rx_d;
   logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
   logic [2:0]  r_rx_idx, w_rx_idx_nxt;
   logic [7:0]  r_rx_shift, w_rx_shift_nxt;
   logic [7:0]  r_rx_data;
   logic        r_rx_valid;
   logic        r_rx_overrun;
   logic        w_rx_done;

   assign w_rx_valid   = r_rx_valid;
   assign w_rx_overrun = r_rx_overrun;
   assign w_rx_byte    = r_rx_data;

   // two-flop synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_rx_s1 <= uart_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
      end
   end

   // RX state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_idx   <= w_rx_idx_nxt;
         r_rx_shift <= w_rx_shift_nxt;
      end
   end

   // RX next state: half-bit wait to the start-bit centre, then whole bits
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt;
      w_rx_idx_nxt   = r_rx_idx;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_done      = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (r_rx_d & ~r_rx_s2) begin
               w_rx_cnt_nxt   = HALF_LAST;
               w_rx_state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (r_rx_cnt == '0) begin
               if (r_rx_s2) begin
                  w_rx_state_nxt = RX_IDLE;
               end else begin
                  w_rx_cnt_nxt   = BAUD_LAST;
                  w_rx_idx_nxt   = '0;
                  w_rx_state_nxt = RX_DATA;
               end
            end else begin
               w_rx_cnt_nxt = r_rx_cnt - 16'd1;
            end
         end
         RX_DATA: begin
            if (r_rx_cnt == '0) begin
               w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
               w_rx_cnt_nxt   = BAUD_LAST;
               if (r_rx_idx == 3'd7) begin
                  w_rx_state_nxt = RX_STOP;
               end else begin
                  w_rx_idx_nxt = r_rx_idx + 3'd1;
               end
            end else begin
               w_rx_cnt_nxt = r_rx_cnt - 16'd1;
            end
         end
         RX_STOP: begin
            if (r_rx_cnt == '0) begin
               w_rx_done      = 1'b1;
               w_rx_state_nxt = RX_IDLE;
            end else begin
               w_rx_cnt_nxt = r_rx_cnt - 16'd1;
            end
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   // RX holding register; a completion in the same cycle as a read wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         if (w_rd_rxdata) begin
            r_rx_valid <= 1'b0;
         end
         if (w_rd_status) begin
            r_rx_overrun <= 1'b0;
         end
         if (w_rx_done) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !w_rd_rxdata) begin
               r_rx_overrun <= 1'b1;
            end
         end
      end
   end
`else
   assign w_rx_valid   = 1'b0;
   assign w_rx_overrun = 1'b0;
   assign w_rx_byte    = '0;
`endif

endmodule

// File: tb/tb_membus_uart.sv
// tb_membus_uart: randomized self-checking bench for membus_uart
// (BAUD_DIV=4, FIFO_DEPTH=4). A serial decoder on uart_tx recovers frames;
// expected values come from frame arithmetic and a small status model.
module tb_membus_uart;

   localparam int unsigned B = 4;
   localparam int unsigned D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic [31:0] mem_addr = '0;
   logic        mem_wen = 1'b0;
   logic [63:0] mem_wdata = '0;
   logic [7:0]  mem_wmask = '0;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx;

   int checks   = 0;
   int failures = 0;
   int unsigned cyc = 0;

   logic [7:0]  mon_q[$];
   logic        mon_stop[$];
   int unsigned mon_t[$];
   bit          mon_en = 1'b1;

   membus_uart #(
      .BAUD_DIV   (B),
      .FIFO_DEPTH (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .uart_rx    (uart_rx),
      .uart_tx    (uart_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // serial decoder: falling edge, then mid-bit samples
   initial begin : monitor
      logic        prev;
      logic [7:0]  b;
      logic        stopb;
      int unsigned t0;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && prev && !uart_tx) begin
            t0 = cyc;
            repeat (B / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (B) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (B) @(negedge clk);
            stopb = uart_tx;
            if (mon_en) begin
               mon_q.push_back(b);
               mon_stop.push_back(stopb);
               mon_t.push_back(t0);
            end
         end
         prev = uart_tx;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
      $fatal(1);
   end

   function automatic logic [63:0] exp_status(int unsigned cnt, bit busy, bit rxv, bit rxo);
      logic [63:0] s;
      s       = '0;
      s[0]    = (cnt == D);
      s[1]    = (cnt == 0);
      s[2]    = busy;
      s[15:8] = 8'(cnt);
      s[16]   = rxv;
      s[17]   = rxo;
      return s;
   endfunction

   function automatic logic [31:0] mk_addr(logic [1:0] sel);
      logic [31:0] a;
      a      = $urandom;
      a[4:3] = sel;
      return a;
   endfunction

   // one request starting at a negedge; returns at the negedge after accept
   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, output logic [63:0] rdata,
                         output int unsigned stall, output logic rv);
      mem_valid = 1'b1;
      mem_wen   = wen;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wmask = wmask;
      stall     = 0;
      #1;
      while (!mem_ready && stall < 2000) begin
         @(negedge clk);
         #1;
         stall++;
      end
      @(posedge clk);
      @(negedge clk);
      mem_valid = 1'b0;
      mem_wen   = 1'b0;
      rv        = mem_rvalid;
      rdata     = mem_rdata;
   endtask

   task automatic read_check(input string name, input logic [1:0] sel, input logic [63:0] exp);
      logic [63:0] rd;
      int unsigned st;
      logic        rv;
      do_req(1'b0, mk_addr(sel), {$urandom, $urandom}, 8'($urandom), rd, st, rv);
      checks++;
      if (rv !== 1'b1 || rd !== exp) begin
         failures++;
         $display("FAIL %s: rvalid=%b rdata=%h required rvalid=1 rdata=%h", name, rv, rd, exp);
      end
   endtask

   task automatic wait_frames(input int unsigned n, input int unsigned budget);
      int unsigned k;
      k = 0;
      while (mon_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (mon_q.size() < n) begin
         failures++;
         $display("FAIL frame_timeout: frames=%0d required=%0d", mon_q.size(), n);
      end
   endtask

   task automatic test_reset();
      logic [63:0] rd;
      int unsigned st;
      logic        rv;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1) begin
         failures++;
         $display("FAIL reset_tx: uart_tx=%b required=1", uart_tx);
      end
      checks++;
      if (mem_rvalid !== 1'b0 || mem_rdata !== 64'd0) begin
         failures++;
         $display("FAIL reset_resp: rvalid=%b rdata=%h required 0/0", mem_rvalid, mem_rdata);
      end
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL idle_tx cycle %0d: uart_tx=%b required=1", i, uart_tx);
         end
      end
      do_req(1'b0, mk_addr(2'd1), '0, 8'h00, rd, st, rv);
      checks++;
      if (rv !== 1'b1 || rd !== 64'h0000_0002) begin
         failures++;
         $display("FAIL reset_status: rvalid=%b rdata=%h required 1/0000000000000002", rv, rd);
      end
      @(negedge clk);
      checks++;
      if (mem_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rvalid_single: rvalid=%b required=0", mem_rvalid);
      end
   endtask

   task automatic test_tx_frame(input logic [7:0] data);
      logic [63:0] rd;
      int unsigned st;
      logic        rv;
      logic [9:0]  fr;
      logic        exp;
      mon_q.delete(); mon_stop.delete(); mon_t.delete();
      fr = {1'b1, data, 1'b0};
      do_req(1'b1, mk_addr(2'd0), {$urandom, $urandom_range(0, 16777215), data},
             8'h01 | 8'($urandom), rd, st, rv);
      checks++;
      if (rv !== 1'b1 || rd !== 64'd0 || st != 0) begin
         failures++;
         $display("FAIL tx_write_resp: rvalid=%b rdata=%h stall=%0d required 1/0/0", rv, rd, st);
      end
      for (int m = 0; m <= int'(10 * B + 2); m++) begin
         exp = (m >= 1 && m <= int'(10 * B)) ? fr[(m - 1) / int'(B)] : 1'b1;
         checks++;
         if (uart_tx !== exp) begin
            failures++;
            $display("FAIL tx_wave data=%h offset=%0d: uart_tx=%b required=%b", data, m + 1, uart_tx, exp);
         end
         @(negedge clk);
      end
      checks++;
      if (mon_q.size() != 1 || mon_q[0] !== data || mon_stop[0] !== 1'b1) begin
         failures++;
         $display("FAIL tx_decode: frames=%0d byte=%h required 1 frame byte=%h",
                  mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 8'hxx, data);
      end
   endtask

   task automatic test_ignored_writes();
      logic [63:0] rd;
      int unsigned st;
      logic        rv;
      logic [7:0]  mask;
      mon_q.delete(); mon_stop.delete(); mon_t.delete();
      for (int i = 0; i < 3; i++) begin
         mask = 8'($urandom) & 8'hFE;
         do_req(1'b1, mk_addr(2'd0), {$urandom, $urandom}, mask, rd, st, rv);
         checks++;
         if (rv !== 1'b1 || rd !== 64'd0) begin
            failures++;
            $display("FAIL nomask_resp mask=%h: rvalid=%b rdata=%h required 1/0", mask, rv, rd);
         end
      end
      do_req(1'b1, mk_addr(2'd1), {$urandom, $urandom}, 8'hFF, rd, st, rv);
      do_req(1'b1, mk_addr(2'd3), {$urandom, $urandom}, 8'hFF, rd, st, rv);
      read_check("nopush_status", 2'd1, exp_status(0, 0, 0, 0));
      read_check("txdata_read", 2'd0, 64'd0);
      read_check("reg3_read", 2'd3, 64'd0);
      repeat (12 * B) @(negedge clk);
      checks++;
      if (mon_q.size() != 0) begin
         failures++;
         $display("FAIL nopush_frames: frames=%0d required=0", mon_q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] rd;
      int unsigned st;
      logic        rv;
      logic [7:0]  bytes[6];
      int unsigned exp_st;
      mon_q.delete(); mon_stop.delete(); mon_t.delete();
      foreach (bytes[k]) bytes[k] = 8'($urandom);
      for (int k = 0; k < 6; k++) begin
         do_req(1'b1, mk_addr(2'd0), {56'($urandom), bytes[k]}, 8'h01, rd, st, rv);
         // byte 1 pops next cycle, so five fit; the sixth waits for the next pop
         // (start of frame 2 at accept0+1+10B+1), then one more cycle for the count
         exp_st = (k < 5) ? 0 : (10 * B + 3 - 5);
         checks++;
         if (st != exp_st || rv !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall write %0d: stall=%0d rvalid=%b required stall=%0d rvalid=1",
                     k, st, rv, exp_st);
         end
      end
      read_check("b2b_full_status", 2'd1, exp_status(D, 1, 0, 0));
      wait_frames(6, 6 * 10 * B + 200);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (k >= mon_q.size() || mon_q[k] !== bytes[k] || mon_stop[k] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_byte %0d: got=%h required=%h", k,
                     (k < mon_q.size()) ? mon_q[k] : 8'hxx, bytes[k]);
         end
         if (k > 0 && k < mon_t.size()) begin
            checks++;
            if (mon_t[k] - mon_t[k - 1] != 10 * B + 1) begin
               failures++;
               $display("FAIL b2b_spacing %0d: period=%0d required=%0d", k,
                        mon_t[k] - mon_t[k - 1], 10 * B + 1);
            end
         end
      end
      repeat (2 * B) @(negedge clk);
      read_check("b2b_done_status", 2'd1, exp_status(0, 0, 0, 0));
   endtask

   task automatic test_reset_midframe();
      logic [63:0] rd;
      int unsigned st;
      logic        rv;
      logic [7:0]  c;
      mon_en = 1'b0;
      do_req(1'b1, mk_addr(2'd0), {56'($urandom), 8'h00}, 8'h01, rd, st, rv);
      do_req(1'b1, mk_addr(2'd0), {$urandom, $urandom}, 8'h01, rd, st, rv);
      repeat (6) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b0) begin
         failures++;
         $display("FAIL mid_data_low: uart_tx=%b required=0", uart_tx);
      end
      rst       = 1'b1;
      mem_valid = 1'b1;
      mem_wen   = 1'b0;
      mem_addr  = mk_addr(2'd1);
      @(negedge clk);
      rst       = 1'b0;
      mem_valid = 1'b0;
      checks++;
      if (uart_tx !== 1'b1 || mem_rvalid !== 1'b0 || mem_rdata !== 64'd0) begin
         failures++;
         $display("FAIL rst_mid: uart_tx=%b rvalid=%b rdata=%h required 1/0/0",
                  uart_tx, mem_rvalid, mem_rdata);
      end
      @(negedge clk);
      checks++;
      if (mem_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rst_drop_resp: rvalid=%b required=0", mem_rvalid);
      end
      read_check("rst_status_empty", 2'd1, exp_status(0, 0, 0, 0));
      for (int i = 0; i < int'(12 * B); i++) begin
         @(negedge clk);
         checks++;
         if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL rst_flushed cycle %0d: uart_tx=%b required=1", i, uart_tx);
         end
      end
      mon_q.delete(); mon_stop.delete(); mon_t.delete();
      mon_en = 1'b1;
      c = 8'($urandom);
      do_req(1'b1, mk_addr(2'd0), {56'($urandom), c}, 8'h01, rd, st, rv);
      wait_frames(1, 12 * B + 20);
      checks++;
      if (mon_q.size() != 1 || mon_q[0] !== c) begin
         failures++;
         $display("FAIL rst_retx: got=%h required=%h", (mon_q.size() > 0) ? mon_q[0] : 8'hxx, c);
      end
      repeat (2 * B) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] v);
      uart_rx = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = v[i];
         repeat (B) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (3 * B) @(negedge clk);
   endtask

   task automatic test_rx();
      logic [7:0] r2;
      r2 = 8'($urandom);
`ifdef MEMBUS_UART_RX_EN
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * B) @(negedge clk);
      read_check("rx_glitch_status", 2'd1, exp_status(0, 0, 0, 0));
      send_rx(8'hA3);
      read_check("rx_valid_status", 2'd1, exp_status(0, 0, 1, 0));
      send_rx(r2);
      read_check("rx_overrun_status", 2'd1, exp_status(0, 0, 1, 1));
      read_check("rx_data", 2'd2, {56'd0, r2});
      read_check("rx_cleared_status", 2'd1, exp_status(0, 0, 0, 0));
      send_rx(8'hA3);
      read_check("rx_data_a3", 2'd2, 64'h0000_0000_0000_00A3);
`else
      send_rx(8'hA3);
      send_rx(r2);
      read_check("norx_status", 2'd1, exp_status(0, 0, 0, 0));
      read_check("norx_rxdata", 2'd2, 64'd0);
`endif
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_tx_frame(8'h55);
      test_tx_frame(8'($urandom));
      test_ignored_writes();
      test_back_to_back();
      test_reset_midframe();
      test_rx();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
